// File: rtl/mul_issue_ctrl_pkg.sv
// Shared op encodings, FSM states and word-select helper
// for the EX-stage multiply issue controller.
package mul_issue_ctrl_pkg;

  localparam int MUL_OP_W = 2;

  localparam logic [MUL_OP_W-1:0] MUL_OP_MUL_W   = 2'b00;
  localparam logic [MUL_OP_W-1:0] MUL_OP_MULH_W  = 2'b01;
  localparam logic [MUL_OP_W-1:0] MUL_OP_MULH_WU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } mul_state_e;

  // Encoding 11 aliases MUL.W, so only the two MULH codes pick the high word.
  function automatic logic [31:0] mul_word_sel(
    input logic [MUL_OP_W-1:0] op,
    input logic [63:0]         prod
  );
    if (op == MUL_OP_MULH_W || op == MUL_OP_MULH_WU)
      return prod[63:32];
    return prod[31:0];
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_wallace_mul.sv
// 32x32 multiplier with one register stage; the product
// appears on result the cycle after the operands are driven.
module Wallace_Mul (
  input  logic        mul_clk,
  input  logic        resetn,
  input  logic        mul_signed,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [63:0] result
);

  logic [63:0] xe;
  logic [63:0] ye;
  logic [63:0] result_d;
  logic [63:0] result_q;

  // 64-bit sign/zero extension keeps the truncated product exact.
  always_comb begin
    xe       = {{32{mul_signed & x[31]}}, x};
    ye       = {{32{mul_signed & y[31]}}, y};
    result_d = xe * ye;
  end

  always_ff @(posedge mul_clk) begin
    if (!resetn) result_q <= '0;
    else         result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// EX-stage sequencer for MUL.W / MULH.W / MULH.WU around Wallace_Mul:
// handshake in, one-cycle latency, hold under backpressure, flush cancel.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_op,
  input  logic [31:0]         in_src1,
  input  logic [31:0]         in_src2,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output logic [TAG_W-1:0]    out_tag
);

  mul_state_e          state_q, state_d;
  logic [MUL_OP_W-1:0] op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [31:0]         hold_result_q, hold_result_d;
  logic [TAG_W-1:0]    hold_tag_q, hold_tag_d;

  logic        accept;
  logic        mul_signed;
  logic [63:0] product;
  logic [31:0] sel_word;

  assign mul_signed = (in_op == MUL_OP_MULH_W);

  Wallace_Mul u_wallace_mul (
    .mul_clk    (clk),
    .resetn     (~reset),
    .mul_signed (mul_signed),
    .x          (in_src1),
    .y          (in_src2),
    .result     (product)
  );

  assign sel_word = mul_word_sel(op_q, product);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    tag_d         = tag_q;
    hold_result_d = hold_result_q;
    hold_tag_d    = hold_tag_q;
    out_valid     = 1'b0;
    out_result    = '0;
    out_tag       = '0;

    in_ready = ~flush & ~reset & ((state_q == ST_IDLE) | out_ready);
    accept   = in_valid & in_ready;

    if (accept) begin
      op_d  = in_op;
      tag_d = in_tag;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_CALC;
      end
      ST_CALC: begin
        out_valid  = 1'b1;
        out_result = sel_word;
        out_tag    = tag_q;
        if (out_ready) begin
          state_d = accept ? ST_CALC : ST_IDLE;
        end else begin
          // Multiplier output is gone next cycle, so park it here.
          state_d       = ST_HOLD;
          hold_result_d = sel_word;
          hold_tag_d    = tag_q;
        end
      end
      ST_HOLD: begin
        out_valid  = 1'b1;
        out_result = hold_result_q;
        out_tag    = hold_tag_q;
        if (out_ready) state_d = accept ? ST_CALC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) state_d = ST_IDLE;

    if (reset) begin
      out_valid  = 1'b0;
      out_result = '0;
      out_tag    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      tag_q         <= '0;
      hold_result_q <= '0;
      hold_tag_q    <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      tag_q         <= tag_d;
      hold_result_q <= hold_result_d;
      hold_tag_q    <= hold_tag_d;
    end
  end

endmodule
